imem_loader: RTL and testbench

Sequencer and arbiter for the unicycle core's writable 16-word instruction memory. At run time it forwards CPU fetches to the memory port. On command it stalls the CPU, takes ownership of the memory port, receives a program as a byte stream over a valid/ready handshake, assembles 16-bit instructions and writes them sequentially from word 0. It replaces the fixed instruction ROM when programs are downloaded from the host.

---
 rtl/imem_loader_pkg.sv | 26 ++
 rtl/imem_loader_port_mux.sv | 27 ++
 rtl/imem_loader.sv | 165 ++++++++++++++++
 tb/tb_imem_loader.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The state set includes ST_CHK, which is only reachable when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_WRITE = 3'd4,
    ST_CHK   = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_e;

  localparam int BYTES_PER_WORD = 2;
  localparam int PC_W           = 16;

  // A CPU byte address fetches real memory only below depth*BYTES_PER_WORD.
  function automatic logic pc_in_range(input logic [PC_W-1:0] pc, input int addr_w);
    logic [PC_W:0] limit;
    limit = (PC_W+1)'(BYTES_PER_WORD) << addr_w;
    return {1'b0, pc} < limit;
  endfunction

endpackage

// File: rtl/imem_loader_port_mux.sv
// Memory-port arbitration: CPU fetch path when the loader is idle, loader
// write address otherwise. Out-of-range fetches and stalled fetches return 0.
module imem_port_mux
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              loader_own,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [PC_W-1:0]   cpu_pc,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] cpu_instr
);

  always_comb begin
    mem_addr  = cpu_pc[ADDR_W:1];
    cpu_instr = '0;
    if (loader_own) begin
      mem_addr = load_addr;
    end else if (pc_in_range(cpu_pc, ADDR_W)) begin
      cpu_instr = mem_rdata;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: stalls the CPU, receives a byte-stream program and
// writes it from word 0. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR check byte.
//
// state    | meaning
// IDLE     | CPU owns the memory port
// LEN      | waiting for word count N
// HI       | waiting for instruction bits [15:8]
// LO       | waiting for instruction bits [7:0]
// WRITE    | one-cycle write of the assembled word
// CHK      | waiting for checksum byte (checksum build only)
// DONE     | one-cycle completion pulse, CPU already released
// ERR      | sticky error, CPU held until a new start
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [PC_W-1:0]   cpu_pc,
  output logic [DATA_W-1:0] cpu_instr,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  // Handshake and status outputs decode from state_q only.
  assign byte_ready = (state_q == ST_LEN) || (state_q == ST_HI) ||
                      (state_q == ST_LO)  || (state_q == ST_CHK);
  assign mem_we     = (state_q == ST_WRITE);
  assign done       = (state_q == ST_DONE);
  assign err        = (state_q == ST_ERR);
  assign cpu_stall  = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign mem_wdata  = word_q;
  assign accept     = byte_valid && byte_ready;
  assign cnt_inc    = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    word_d  = word_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (accept) begin
          if ((byte_in == 8'd0) || (32'(byte_in) > 32'(DEPTH))) begin
            state_d = ST_ERR;
          end else begin
            len_d   = CNT_W'(byte_in);
            cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d  = '0;
`endif
            state_d = ST_HI;
          end
        end
      end
      ST_HI: begin
        if (accept) begin
          word_d  = {byte_in, word_q[7:0]};
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ byte_in;
`endif
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (accept) begin
          word_d  = {word_q[15:8], byte_in};
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ byte_in;
`endif
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        cnt_d = cnt_inc;
        if (cnt_inc == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_HI;
        end
      end
      ST_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) state_d = (byte_in == csum_q) ? ST_DONE : ST_ERR;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (start) state_d = ST_LEN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      word_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      word_q  <= word_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  imem_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port_mux (
    .loader_own (cpu_stall),
    .load_addr  (cnt_q[ADDR_W-1:0]),
    .cpu_pc     (cpu_pc),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .cpu_instr  (cpu_instr)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes and done latencies are queued
// by the stimulus and checked by a negedge monitor against a behavioural memory.
module tb_imem_loader;

  localparam int ADDR_W = 4;

  logic        clk = 1'b0;
  logic        rst_n, start, byte_valid, mem_init_req;
  logic [7:0]  byte_in;
  logic [15:0] cpu_pc;
  logic        byte_ready, cpu_stall, mem_we, done, err;
  logic [15:0] cpu_instr, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  logic [15:0] mem     [16];
  logic [15:0] exp_mem [16];

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;
  wr_t wr_q[$];
  int  done_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;
  int start_edge = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  wr_t mon_e;
  int  mon_l;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int LAT_EXTRA = 3;
`else
  localparam int LAT_EXTRA = 2;
`endif

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .cpu_pc     (cpu_pc),
    .cpu_instr  (cpu_instr),
    .cpu_stall  (cpu_stall),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .done       (done),
    .err        (err)
  );

  function automatic logic [15:0] init_val(input int i);
    return (i == 2) ? 16'hDC67 : (16'hA000 | 16'(i));
  endfunction

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (mem_init_req) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt++;
      if (wr_q.size() == 0) begin
        check("unexpected_write_addr", 32'(mem_addr), 32'hFFFF);
      end else begin
        mon_e = wr_q.pop_front();
        check("write_addr", 32'(mem_addr), 32'(mon_e.a));
        check("write_data", 32'(mem_wdata), 32'(mon_e.d));
      end
    end
    if (done) begin
      done_cnt++;
      if (done_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_l = done_q.pop_front();
        if (mon_l >= 0) check("done_cycle", 32'(edge_cnt - start_edge + 1), 32'(mon_l));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    start_edge = edge_cnt + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    int guard;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) tick();
    end
    byte_in = b;
    byte_valid = 1'b1;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 20) begin
      @(negedge clk);
      acc = byte_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) check("byte_accept_timeout", 32'(b), 32'hFFFF_FFFF);
  endtask

  task automatic wait_done(input int d0);
    int guard = 0;
    while (done_cnt == d0 && guard < 30) begin
      tick();
      guard++;
    end
    check("done_seen", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic load(input int n, input logic [15:0] w [4], input int gap, input bit best);
    logic [7:0] ck;
    int d0;
    ck = 8'h00;
    d0 = done_cnt;
    done_q.push_back(best ? (3 * n + LAT_EXTRA) : -1);
    do_start();
    check("load_stall", 32'(cpu_stall), 32'd1);
    check("load_instr_zero", 32'(cpu_instr), 32'd0);
    check("load_err_clear", 32'(err), 32'd0);
    send_byte(8'(n), gap);
    for (int i = 0; i < n; i++) begin
      wr_q.push_back('{a: 4'(i), d: w[i]});
      exp_mem[i] = w[i];
      send_byte(w[i][15:8], gap);
      send_byte(w[i][7:0], gap);
      ck = ck ^ w[i][15:8] ^ w[i][7:0];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(ck, gap);
`endif
    byte_valid = 1'b0;
    wait_done(d0);
  endtask

  task automatic check_mem();
    for (int i = 0; i < 16; i++) check($sformatf("mem_word_%0d", i), 32'(mem[i]), 32'(exp_mem[i]));
  endtask

  logic [15:0] wv [4];
  int we0;

  initial begin
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    cpu_pc = 16'h0004; mem_init_req = 1'b1;
    for (int i = 0; i < 16; i++) exp_mem[i] = init_val(i);
    repeat (3) tick();
    rst_n = 1'b1; mem_init_req = 1'b0;
    tick();

    // reset state and CPU fetch path
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("fetch_pc4", 32'(cpu_instr), 32'hDC67);
    cpu_pc = 16'h0020; #1;
    check("fetch_out_of_range", 32'(cpu_instr), 32'd0);
    cpu_pc = 16'h001F; #1;
    check("fetch_last_addr", 32'(mem_addr), 32'd15);
    check("fetch_last_word", 32'(cpu_instr), 32'hA00F);
    cpu_pc = 16'h0004;

    // best-case two-word load
    wv = '{16'h8000, 16'h2CB2, 16'h0000, 16'h0000};
    load(2, wv, 0, 1'b1);
    tick();
    check("post_load_stall", 32'(cpu_stall), 32'd0);
    check_mem();
    cpu_pc = 16'h0000; #1;
    check("fetch_word0", 32'(cpu_instr), 32'h8000);
    cpu_pc = 16'h0002; #1;
    check("fetch_word1", 32'(cpu_instr), 32'h2CB2);
    cpu_pc = 16'h0004;

`ifndef IMEM_LOADER_CHECKSUM_EN
    // a trailing byte is never accepted while idle
    byte_in = 8'h55; byte_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_ready_low", 32'(byte_ready), 32'd0);
    end
    tick();
    byte_valid = 1'b0;
`endif

    // zero and oversize lengths
    do_start();
    send_byte(8'h00, 0);
    byte_valid = 1'b0;
    check("len0_err", 32'(err), 32'd1);
    check("len0_stall", 32'(cpu_stall), 32'd1);
    check("len0_ready", 32'(byte_ready), 32'd0);
    check("len0_instr", 32'(cpu_instr), 32'd0);
    repeat (3) tick();
    check("err_sticky", 32'(err), 32'd1);
    do_start();
    check("restart_clears_err", 32'(err), 32'd0);
    send_byte(8'h11, 0);
    byte_valid = 1'b0;
    check("len17_err", 32'(err), 32'd1);
    wv = '{16'hBEEF, 16'h0000, 16'h0000, 16'h0000};
    load(1, wv, 0, 1'b1);
    tick();
    check("recover_err", 32'(err), 32'd0);

    // byte_valid gaps during a three-word load
    we0 = we_cnt;
    wv = '{16'h1111, 16'hA5C3, 16'h0F0F, 16'h0000};
    load(3, wv, 1, 1'b0);
    check("gap_write_count", 32'(we_cnt - we0), 32'd3);
    check_mem();

    // reset in LO of word 1
    do_start();
    send_byte(8'h02, 0);
    wr_q.push_back('{a: 4'd0, d: 16'h1122});
    exp_mem[0] = 16'h1122;
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    byte_valid = 1'b0;
    check("in_lo_ready", 32'(byte_ready), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_stall", 32'(cpu_stall), 32'd0);
    check("midrst_ready", 32'(byte_ready), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    repeat (2) tick();
    check("midrst_word0", 32'(mem[0]), 32'h1122);
    check("midrst_word1", 32'(mem[1]), 32'(exp_mem[1]));

`ifdef IMEM_LOADER_CHECKSUM_EN
    // checksum: 0x12 ^ 0x34 = 0x26
    wv = '{16'h1234, 16'h0000, 16'h0000, 16'h0000};
    load(1, wv, 0, 1'b1);
    tick();
    check("ck_good_err", 32'(err), 32'd0);
    do_start();
    wr_q.push_back('{a: 4'd0, d: 16'h1234});
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h27, 0);
    byte_valid = 1'b0;
    check("ck_bad_err", 32'(err), 32'd1);
    check("ck_bad_stall", 32'(cpu_stall), 32'd1);
`endif

    repeat (3) tick();
    check("pending_writes", 32'(wr_q.size()), 32'd0);
    check("pending_done", 32'(done_q.size()), 32'd0);
    check_mem();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
